// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: register addresses, STATUS/CTRL
// bit positions and the frame state encoding.
package spi_target_pkg;

    // Register addresses on the 6502-side bus
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_TXDATA = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_VALID  = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_ABORT     = 3;
    localparam int ST_CS_ACTIVE = 4;

    // CTRL bit positions (CLR_* are write-one-to-clear strobes, read as 0)
    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_CLR_OVR   = 1;
    localparam int CTRL_CLR_ABT   = 2;
    localparam int CTRL_RX_IRQ_EN = 3;
    localparam int CTRL_TX_IRQ_EN = 4;

    // Frame state: ACTIVE while the master holds chip select low
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall
// detection against the previous synchronised value.
module spi_target_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the pin through the synchroniser and remember the last synced value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_target.sv
// SPI target (mode 0, MSB first) with a 6502-style register interface.
// Optional feature macro: SPI_TARGET_IRQ_EN adds o_irq and CTRL irq enables.
// Bus handshake: a single-cycle access; i_cs=1 at an i_clk rising edge is the
// transfer. Writes (i_rwb=0) and the RXDATA read side effect happen on that
// edge; o_data is combinational from i_addr and valid whenever i_cs=1.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs,
    input  logic       i_rwb,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_spi_cs,
    input  logic       i_spi_clk,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_spi_miso_oe
`ifdef SPI_TARGET_IRQ_EN
    ,
    output logic       o_irq
`endif
);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(i_clk), .rst_n(i_rst_n), .async_in(i_spi_cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(i_clk), .rst_n(i_rst_n), .async_in(i_spi_clk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(i_clk), .rst_n(i_rst_n), .async_in(i_spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Registers
    state_t     state, state_d;
    logic       enable;
    logic [7:0] rx_data, tx_buf, tx_shift;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       rx_valid, tx_empty, overrun, abort;
`ifdef SPI_TARGET_IRQ_EN
    logic       rx_irq_en, tx_irq_en;
`endif

    // Decoded strobes
    logic       wr_tx, wr_ctrl, rd_rx;
    logic       tx_load, tx_shl, rx_step, rx_done, go_idle, frame_abort;
    logic [7:0] rx_byte;
    logic       unused_ok;

    assign wr_tx     = i_cs & ~i_rwb & (i_addr == ADDR_TXDATA);
    assign wr_ctrl   = i_cs & ~i_rwb & (i_addr == ADDR_CTRL);
    assign rd_rx     = i_cs &  i_rwb & (i_addr == ADDR_RXDATA);
    assign rx_byte   = {rx_shift, mosi_level};
    assign unused_ok = &{1'b0, sclk_level, mosi_rise, mosi_fall, i_data};

    // Frame FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next state, per-cycle datapath strobes and pin outputs
    always_comb begin
        state_d       = state;
        tx_load       = 1'b0;
        tx_shl        = 1'b0;
        rx_step       = 1'b0;
        rx_done       = 1'b0;
        go_idle       = 1'b0;
        frame_abort   = 1'b0;
        o_spi_miso    = 1'b1;
        o_spi_miso_oe = 1'b0;
        case (state)
            IDLE: begin
                if (enable && cs_fall) begin
                    state_d = ACTIVE;
                    tx_load = 1'b1;
                end
            end
            ACTIVE: begin
                o_spi_miso    = tx_shift[7];
                o_spi_miso_oe = 1'b1;
                if (!enable || cs_rise) begin
                    state_d     = IDLE;
                    go_idle     = 1'b1;
                    frame_abort = (bit_cnt != 3'd0);
                end else if (sclk_rise) begin
                    rx_step = 1'b1;
                    rx_done = (bit_cnt == 3'd7);
                end else if (sclk_fall) begin
                    tx_load = (bit_cnt == 3'd0);
                    tx_shl  = (bit_cnt != 3'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers and bit counter; the counter stays 0 outside a frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_shift <= IDLE_BYTE;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            if (tx_load)      tx_shift <= tx_empty ? IDLE_BYTE : tx_buf;
            else if (tx_shl)  tx_shift <= {tx_shift[6:0], 1'b0};
            if (rx_step)      rx_shift <= rx_byte[6:0];
            if (go_idle || state == IDLE) bit_cnt <= '0;
            else if (rx_step)             bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // CPU-visible registers; a bus write to TXDATA beats a same-cycle load,
    // a byte completion beats a same-cycle RXDATA read, flag sets beat clears
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_buf   <= IDLE_BYTE;
            tx_empty <= 1'b1;
            overrun  <= 1'b0;
            abort    <= 1'b0;
`ifdef SPI_TARGET_IRQ_EN
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
`endif
        end else begin
            if (wr_tx) begin
                tx_buf   <= i_data;
                tx_empty <= 1'b0;
            end else if (tx_load && !tx_empty) begin
                tx_empty <= 1'b1;
            end
            if (wr_ctrl) begin
                enable <= i_data[CTRL_ENABLE];
                if (i_data[CTRL_CLR_OVR]) overrun <= 1'b0;
                if (i_data[CTRL_CLR_ABT]) abort   <= 1'b0;
`ifdef SPI_TARGET_IRQ_EN
                rx_irq_en <= i_data[CTRL_RX_IRQ_EN];
                tx_irq_en <= i_data[CTRL_TX_IRQ_EN];
`endif
            end
            if (rx_done) begin
                if (!rx_valid || rd_rx) begin
                    rx_data  <= rx_byte;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (frame_abort) abort <= 1'b1;
        end
    end

`ifdef SPI_TARGET_IRQ_EN
    // Registered interrupt request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_irq <= 1'b0;
        else          o_irq <= (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty) | overrun;
    end
`endif

    // Read mux; unmapped bits and write-only locations read 0
    always_comb begin
        o_data = '0;
        case (i_addr)
            ADDR_STATUS: begin
                o_data[ST_RX_VALID]  = rx_valid;
                o_data[ST_TX_EMPTY]  = tx_empty;
                o_data[ST_OVERRUN]   = overrun;
                o_data[ST_ABORT]     = abort;
                o_data[ST_CS_ACTIVE] = ~cs_level;
            end
            ADDR_RXDATA: o_data = rx_data;
            ADDR_CTRL: begin
                o_data[CTRL_ENABLE] = enable;
`ifdef SPI_TARGET_IRQ_EN
                o_data[CTRL_RX_IRQ_EN] = rx_irq_en;
                o_data[CTRL_TX_IRQ_EN] = tx_irq_en;
`endif
            end
            default: o_data = '0;
        endcase
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: CPU bus driver, SPI master driver,
// and monitors that compare bus reads and MISO bytes against expected queues.
module tb_spi_target;
    import spi_target_pkg::*;

    logic       i_clk, i_rst_n, i_cs, i_rwb;
    logic [1:0] i_addr;
    logic [7:0] i_data, o_data;
    logic       i_spi_cs, i_spi_clk, i_spi_mosi, o_spi_miso, o_spi_miso_oe;
`ifdef SPI_TARGET_IRQ_EN
    logic       o_irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] miso_q[$];

    spi_target dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cs(i_cs), .i_rwb(i_rwb),
        .i_addr(i_addr), .i_data(i_data), .o_data(o_data),
        .i_spi_cs(i_spi_cs), .i_spi_clk(i_spi_clk), .i_spi_mosi(i_spi_mosi),
        .o_spi_miso(o_spi_miso), .o_spi_miso_oe(o_spi_miso_oe)
`ifdef SPI_TARGET_IRQ_EN
        , .o_irq(o_irq)
`endif
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Bus read monitor: o_data is sampled on the falling edge of a read cycle
    always @(negedge i_clk) begin : bus_mon
        logic [7:0] e;
        string      n;
        if (i_cs && i_rwb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_read: unexpected read data %02h", o_data);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, o_data, e);
            end
        end
    end

    // MISO monitor: master samples on SCLK rising; chip select high discards partial bytes
    int         miso_bits = 0;
    logic [7:0] miso_sr   = '0;
    always @(posedge i_spi_clk or posedge i_spi_cs) begin : miso_mon
        logic [7:0] e;
        if (i_spi_cs) begin
            miso_bits = 0;
        end else begin
            miso_sr = {miso_sr[6:0], o_spi_miso};
            miso_bits++;
            if (miso_bits == 8) begin
                miso_bits = 0;
                if (miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_byte: unexpected byte %02h", miso_sr);
                end else begin
                    e = miso_q.pop_front();
                    check("miso_byte", miso_sr, e);
                end
            end
        end
    end

    // CPU bus driver tasks
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge i_clk); #1;
        i_cs = 1'b1; i_rwb = 1'b0; i_addr = a; i_data = d;
        @(posedge i_clk); #1;
        i_cs = 1'b0; i_rwb = 1'b1;
    endtask

    task automatic bus_read_exp(input logic [1:0] a, input logic [7:0] e, input string n);
        @(posedge i_clk); #1;
        exp_q.push_back(e);
        name_q.push_back(n);
        i_cs = 1'b1; i_rwb = 1'b1; i_addr = a;
        @(posedge i_clk); #1;
        i_cs = 1'b0;
    endtask

    // SPI master driver tasks (SCLK = i_clk/16, mode 0)
    task automatic spi_bits(input logic [7:0] tx, input int n);
        @(posedge i_clk); #3;
        for (int i = 7; i > 7 - n; i--) begin
            i_spi_mosi = tx[i];
            #80 i_spi_clk = 1'b1;
            #80 i_spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(posedge i_clk); #3;
        i_spi_cs = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80 i_spi_cs = 1'b1;
        repeat (8) @(posedge i_clk);
    endtask

    task automatic spi_frame(input logic [7:0] mosi_byte, input logic [7:0] miso_exp);
        miso_q.push_back(miso_exp);
        cs_low();
        spi_bits(mosi_byte, 8);
        cs_high();
    endtask

    initial begin
        i_rst_n = 1'b0; i_cs = 1'b0; i_rwb = 1'b1; i_addr = ADDR_STATUS; i_data = '0;
        i_spi_cs = 1'b1; i_spi_clk = 1'b0; i_spi_mosi = 1'b0;
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b1;

        // Reset state
        check("reset_oe", {7'd0, o_spi_miso_oe}, 8'h00);
        check("reset_miso", {7'd0, o_spi_miso}, 8'h01);
        bus_read_exp(ADDR_STATUS, 8'h02, "reset_status");
        bus_read_exp(ADDR_CTRL,   8'h00, "reset_ctrl");
        bus_read_exp(ADDR_RXDATA, 8'h00, "reset_rxdata");

        // Basic exchange
        bus_write(ADDR_CTRL, 8'h01);
        bus_write(ADDR_TXDATA, 8'h55);
        bus_read_exp(ADDR_STATUS, 8'h00, "status_tx_pending");
        spi_frame(8'hAA, 8'h55);
        bus_read_exp(ADDR_STATUS, 8'h03, "status_after_rx");
        bus_read_exp(ADDR_RXDATA, 8'hAA, "rxdata_basic");
        bus_read_exp(ADDR_STATUS, 8'h02, "status_rx_cleared");

        // Underrun
        spi_frame(8'h3C, 8'hFF);
        bus_read_exp(ADDR_RXDATA, 8'h3C, "rxdata_underrun");

        // Overrun
        spi_frame(8'h11, 8'hFF);
        spi_frame(8'h22, 8'hFF);
        bus_read_exp(ADDR_STATUS, 8'h07, "status_overrun");
        bus_read_exp(ADDR_RXDATA, 8'h11, "rxdata_overrun_keeps_first");
        bus_write(ADDR_CTRL, 8'h03);
        bus_read_exp(ADDR_CTRL,   8'h01, "ctrl_after_clear");
        bus_read_exp(ADDR_STATUS, 8'h02, "status_overrun_cleared");

        // Abort after 5 SCLK pulses
        cs_low();
        spi_bits(8'hF8, 5);
        cs_high();
        check("abort_oe", {7'd0, o_spi_miso_oe}, 8'h00);
        check("abort_miso", {7'd0, o_spi_miso}, 8'h01);
        bus_read_exp(ADDR_STATUS, 8'h0A, "status_abort");
        bus_write(ADDR_CTRL, 8'h05);
        bus_read_exp(ADDR_STATUS, 8'h02, "status_abort_cleared");
        spi_frame(8'h7E, 8'hFF);
        bus_read_exp(ADDR_RXDATA, 8'h7E, "rxdata_after_abort");

        // Multi-byte frame with a TX reload and an RX read mid-frame
        bus_write(ADDR_TXDATA, 8'hA1);
        miso_q.push_back(8'hA1);
        miso_q.push_back(8'hB2);
        cs_low();
        fork
            spi_bits(8'h01, 8);
            begin
                repeat (20) @(posedge i_clk);
                bus_write(ADDR_TXDATA, 8'hB2);
            end
        join
        fork
            spi_bits(8'h02, 8);
            begin
                repeat (20) @(posedge i_clk);
                bus_read_exp(ADDR_RXDATA, 8'h01, "rxdata_multi_byte1");
            end
        join
        cs_high();
        bus_read_exp(ADDR_RXDATA, 8'h02, "rxdata_multi_byte2");
        bus_read_exp(ADDR_STATUS, 8'h02, "status_multi_no_overrun");

        // Asynchronous reset mid-byte
        i_addr = ADDR_STATUS;
        cs_low();
        spi_bits(8'hA5, 3);
        #40 i_rst_n = 1'b0;
        #1;
        check("midreset_oe", {7'd0, o_spi_miso_oe}, 8'h00);
        check("midreset_miso", {7'd0, o_spi_miso}, 8'h01);
        check("midreset_status", o_data, 8'h02);
        i_addr = ADDR_CTRL;
        #1 check("midreset_ctrl", o_data, 8'h00);
        i_addr = ADDR_RXDATA;
        #1 check("midreset_rxdata", o_data, 8'h00);
        cs_high();
        @(posedge i_clk); #3 i_rst_n = 1'b1;
        bus_write(ADDR_CTRL, 8'h01);
        bus_write(ADDR_TXDATA, 8'h5A);
        spi_frame(8'hC3, 8'h5A);
        bus_read_exp(ADDR_RXDATA, 8'hC3, "rxdata_after_reset");
        bus_read_exp(ADDR_STATUS, 8'h02, "status_after_reset_frame");

`ifdef SPI_TARGET_IRQ_EN
        // Interrupt follows rx_valid when rx_irq_en is set
        bus_write(ADDR_CTRL, 8'h09);
        bus_read_exp(ADDR_CTRL, 8'h09, "ctrl_irq_en");
        check("irq_idle", {7'd0, o_irq}, 8'h00);
        spi_frame(8'h66, 8'hFF);
        check("irq_on_rx", {7'd0, o_irq}, 8'h01);
        bus_read_exp(ADDR_RXDATA, 8'h66, "rxdata_irq");
        repeat (2) @(posedge i_clk);
        #1 check("irq_cleared", {7'd0, o_irq}, 8'h00);
`endif

        repeat (4) @(posedge i_clk);
        checks++;
        if (exp_q.size() != 0 || miso_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: bus %0d miso %0d entries still queued, required 0",
                     exp_q.size(), miso_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
SPI target (slave) with a 6502-bus register interface: the responder at the far end of the link driven by spi_controller. An external SPI master clocks bytes in on MOSI while the CPU reads received bytes and preloads reply bytes. It works in SPI mode 0, MSB first, and oversamples the SPI pins on the single system clock.

Parameters:
IDLE_BYTE, 8'hFF, byte shifted out on MISO when no TX byte is pending (underrun).
SYNC_STAGES, 2, flops in each SPI input synchroniser (min 2).

Ports:
i_clk  input  1  system clock; required i_clk >= 8x SCLK frequency.
i_rst_n  input  1  asynchronous active-low reset.
i_cs  input  1  register select, sampled on i_clk rising.
i_rwb  input  1  1 = read, 0 = write.
i_addr  input  2  register address.
i_data  input  8  write data.
o_data  output  8  read data, combinational from i_addr.
i_spi_cs  input  1  SPI chip select, active low, asynchronous.
i_spi_clk  input  1  SCLK, asynchronous.
i_spi_mosi  input  1  MOSI, asynchronous.
o_spi_miso  output  1  MISO data.
o_spi_miso_oe  output  1  MISO output enable, for the pad tristate.

Behaviour:
- Register map:
  - 0 STATUS (read-only): b0 rx_valid, b1 tx_empty, b2 overrun, b3 abort, b4 cs_active (synchronised).
  - 1 RXDATA (read): a read clears rx_valid.
  - 2 TXDATA (write): loads tx_buf and clears tx_empty. A write while tx_empty=0 overwrites tx_buf.
  - 3 CTRL (R/W): b0 enable. Writing 1 to b1 clears overrun; writing 1 to b2 clears abort. b1/b2 read back 0.
- Bus timing: a write takes effect at the i_clk rising edge where i_cs=1 and i_rwb=0. Read side effects happen at the rising edge where i_cs=1, i_rwb=1 and i_addr=1. Unmapped bits read 0.
- Reset values: ctrl.enable=0, rx_data=0, rx_valid=0, tx_buf=IDLE_BYTE, tx_empty=1, overrun=0, abort=0, o_spi_miso=1, o_spi_miso_oe=0, o_data follows the register contents.
- Input handling: SPI inputs pass through SYNC_STAGES flops (cs resets to 1, clk/mosi reset to 0). Edges are detected against the previous synced value.
- enable=0: all SPI activity is ignored, bit_cnt is held at 0, oe=0.
- FSM states:
  - IDLE: on synced cs falling with enable=1, go to ACTIVE. bit_cnt=0. tx_shift is loaded with tx_buf if tx_empty=0 (then tx_empty<=1), otherwise with IDLE_BYTE.
  - ACTIVE, SCLK rising: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++ (3-bit, wraps 7 -> 0).
  - ACTIVE, rising edge completing the 8th bit: if rx_valid=0, rx_data <= the full byte and rx_valid<=1. If rx_valid=1, the new byte is discarded and overrun<=1.
  - ACTIVE, SCLK falling: if bit_cnt==0 (byte boundary), reload tx_shift using the same rule as the IDLE load. Otherwise tx_shift <= tx_shift<<1.
  - ACTIVE, cs rising: return to IDLE. If bit_cnt!=0, the partial RX byte is dropped, abort<=1, and the consumed TX byte is lost.
  - ACTIVE, enable cleared: return to IDLE immediately with the same rules as cs rising.
- Outputs: o_spi_miso = tx_shift[7] in ACTIVE, 1 in IDLE. o_spi_miso_oe = ACTIVE.
- Latency: rx_valid sets 3 i_clk cycles (with SYNC_STAGES=2) after the 8th SCLK rising edge reaches the pin. MISO changes 3 cycles after the SCLK falling edge.
- Simultaneous events:
  - RXDATA read in the same cycle as a byte completion: the completion wins (rx_valid stays 1, new data) and no overrun is flagged.
  - TXDATA write in the same cycle as a tx_shift load: the load uses the pre-write tx_buf/tx_empty, and the written byte remains pending (tx_empty=0).
- Reset mid-frame: everything returns to reset values. The frame resumes only after cs rises and falls again.

Optional Feature:
SPI_TARGET_IRQ_EN
- Defined:
  - Adds output o_irq (1 bit, resets to 0) and CTRL b3 rx_irq_en and b4 tx_irq_en (both reset 0).
  - o_irq = (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty) | overrun, registered (1 cycle).
- Undefined: no o_irq port; CTRL b3/b4 read 0 and writes to them are ignored.

Decomposition:
- Package spi_target_pkg holds:
  - register address localparams (ADDR_STATUS=0, ADDR_RXDATA=1, ADDR_TXDATA=2, ADDR_CTRL=3);
  - STATUS/CTRL bit-index constants;
  - the FSM state enum (IDLE, ACTIVE).
- Sub-module spi_target_sync: a parameterised SYNC_STAGES synchroniser plus rise/fall edge detect, instantiated for cs, clk and mosi.

Test Plan:
- Basic exchange: enable=1, TXDATA=8'h55; master (SCLK = i_clk/16) sends 8'hAA -> master receives 8'h55; STATUS=8'h03 (rx_valid, tx_empty); RXDATA=8'hAA; STATUS b0 then 0.
- Underrun: no TXDATA written, master sends 8'h3C -> master receives IDLE_BYTE 8'hFF; RXDATA=8'h3C.
- Overrun: master sends 8'h11 then 8'h22 with no RXDATA read -> RXDATA=8'h11, overrun=1; CTRL write 8'h03 clears overrun, enable stays 1.
- Abort: cs raised after 5 SCLK pulses -> rx_valid=0, abort=1, oe=0, MISO=1; next full frame of 8'h7E is received correctly.
- Multi-byte frame: CPU writes 8'hA1 before the frame and 8'hB2 during byte 1 -> master receives A1,B2; CPU reads both MOSI bytes 8'h01,8'h02 in order.
- Async reset asserted mid-byte -> every register is at its reset value within the same cycle; a subsequent frame works; with SPI_TARGET_IRQ_EN and rx_irq_en=1, o_irq rises 1 cycle after rx_valid.
